// File: rtl/sig_normalizer_pkg.sv
// Shared FMA datapath definitions used by the post-add normalization stage.
package sig_normalizer_pkg;

    localparam int SIG_W_DEF = 24;
    localparam int EXP_W_DEF = 8;

    localparam logic [EXP_W_DEF-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SHIFT,
        DONE
    } norm_state_t;

    typedef struct packed {
        logic zero;
        logic underflow;
        logic overflow;
    } norm_flags_t;

endpackage

// File: rtl/sig_normalizer_if.sv
// Handshake bundle between the add/subtract stage, the normalizer and its consumer.
interface sig_normalizer_if
    import sig_normalizer_pkg::*;
#(
    parameter int SIG_W = SIG_W_DEF,
    parameter int EXP_W = EXP_W_DEF
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [SIG_W:0]   in_sig;

    logic             out_valid;
    logic             out_ready;
    logic             out_sign;
    logic [EXP_W-1:0] out_exp;
    logic [SIG_W-1:0] out_sig;
    logic             out_zero;
    logic             out_underflow;
    logic             out_overflow;

    modport master (
        output in_valid, in_sign, in_exp, in_sig, out_ready,
        input  in_ready, out_valid, out_sign, out_exp, out_sig,
               out_zero, out_underflow, out_overflow
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_sig, out_ready,
        output in_ready, out_valid, out_sign, out_exp, out_sig,
               out_zero, out_underflow, out_overflow
    );

endinterface

// File: rtl/sig_normalizer.sv
// Post-add normalizer: handles carry-out, then left-shifts one bit per cycle
// until the hidden bit is set, saturating/clamping the exponent at the edges.
module sig_normalizer
    import sig_normalizer_pkg::*;
#(
    parameter int SIG_W = SIG_W_DEF,
    parameter int EXP_W = EXP_W_DEF
) (
    input logic             clk,
    input logic             rst,
    sig_normalizer_if.slave bus
);

    localparam logic [EXP_W-1:0] EXP_ALL1 = '1;
    localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);

    norm_state_t      state_q, state_d;
    norm_flags_t      flags_q, flags_d;
    logic             sign_q, sign_d;
    logic [EXP_W-1:0] exp_q, exp_d;
    logic [SIG_W:0]   sig_q, sig_d;

    always_comb begin
        state_d = state_q;
        flags_d = flags_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        sig_d   = sig_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.in_sign;
                    exp_d   = bus.in_exp;
                    sig_d   = bus.in_sig;
                    flags_d = '0;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                state_d = DONE;
                if (sig_q == '0) begin
                    flags_d.zero = 1'b1;
                    exp_d        = '0;
                end else if (sig_q[SIG_W]) begin
                    // Saturate rather than wrap when the increment would reach all-ones.
                    if (exp_q >= EXP_ALL1 - EXP_ONE) begin
                        exp_d            = EXP_ALL1;
                        sig_d            = '0;
                        flags_d.overflow = 1'b1;
                    end else begin
                        exp_d = exp_q + EXP_ONE;
                        sig_d = sig_q >> 1;
                    end
                end else if (sig_q[SIG_W-1]) begin
                    state_d = DONE;
                end else if (exp_q <= EXP_ONE) begin
                    exp_d             = '0;
                    flags_d.underflow = 1'b1;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sig_d = {sig_q[SIG_W-1:0], 1'b0};
                exp_d = exp_q - EXP_ONE;
                if (sig_d[SIG_W-1]) begin
                    state_d = DONE;
                end else if (exp_d == EXP_ONE) begin
                    exp_d             = '0;
                    flags_d.underflow = 1'b1;
                    state_d           = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    flags_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            flags_q <= flags_d;
        end
    end

    // Datapath registers carry no reset; outputs are gated by out_valid instead.
    always_ff @(posedge clk) begin
        sign_q <= sign_d;
        exp_q  <= exp_d;
        sig_q  <= sig_d;
    end

    assign bus.in_ready      = (state_q == IDLE);
    assign bus.out_valid     = (state_q == DONE);
    assign bus.out_sign      = bus.out_valid ? sign_q : 1'b0;
    assign bus.out_exp       = bus.out_valid ? exp_q : '0;
    assign bus.out_sig       = bus.out_valid ? sig_q[SIG_W-1:0] : '0;
    assign bus.out_zero      = bus.out_valid & flags_q.zero;
    assign bus.out_underflow = bus.out_valid & flags_q.underflow;
    assign bus.out_overflow  = bus.out_valid & flags_q.overflow;

endmodule

// File: tb/tb_sig_normalizer.sv
// Directed bench for sig_normalizer: a reference model predicts result and
// latency per accepted input, and a negedge monitor compares every valid cycle.
module tb_sig_normalizer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sig_normalizer_if #(.SIG_W(24), .EXP_W(8)) bus ();

    sig_normalizer #(.SIG_W(24), .EXP_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit        sign;
        bit [7:0]  e;
        bit [23:0] s;
        bit        z;
        bit        u;
        bit        o;
        int        lat;
        int        due;
    } res_t;

    res_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   pcyc   = 0;
    bit   shown  = 0;

    always @(posedge clk) pcyc = pcyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk = n_chk + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Expected result straight from the normalization rules.
    function automatic res_t model(input bit sg, input bit [7:0] e, input bit [24:0] s);
        res_t r;
        int   ei;
        int   lz;
        int   n;
        ei    = int'(e);
        r.sign = sg;
        r.z = 0; r.u = 0; r.o = 0;
        r.lat = 2; r.due = 0;
        r.e = e; r.s = s[23:0];
        if (s == 25'd0) begin
            r.z = 1; r.e = 8'd0; r.s = 24'd0;
        end else if (s[24]) begin
            if (ei + 1 >= 255) begin
                r.e = 8'hFF; r.s = 24'd0; r.o = 1;
            end else begin
                r.e = 8'(ei + 1); r.s = s[24:1];
            end
        end else if (s[23]) begin
            r.e = e;
        end else if (ei <= 1) begin
            r.e = 8'd0; r.u = 1;
        end else begin
            lz = 0;
            while (!s[23-lz]) lz = lz + 1;
            if (lz <= ei - 1) begin
                r.s = s[23:0] << lz; r.e = 8'(ei - lz); r.lat = 2 + lz;
            end else begin
                n = ei - 1;
                r.s = s[23:0] << n; r.e = 8'd0; r.u = 1; r.lat = 2 + n;
            end
        end
        return r;
    endfunction

    // Monitor: every valid cycle is checked against the oldest outstanding result.
    always @(negedge clk) begin
        if (!rst && bus.out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out_valid", 64'd1, 64'd0);
            end else begin
                if (!shown) begin
                    chk("latency", 64'(pcyc), 64'(q[0].due));
                    shown = 1;
                end
                chk("result", {bus.out_sign, bus.out_exp, bus.out_sig,
                               bus.out_zero, bus.out_underflow, bus.out_overflow},
                    {q[0].sign, q[0].e, q[0].s, q[0].z, q[0].u, q[0].o});
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    shown = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sg, input bit [7:0] e, input bit [24:0] s);
        res_t r;
        int   t = 0;
        while (!bus.in_ready && t < 200) begin
            tick();
            t = t + 1;
        end
        if (!bus.in_ready) chk("send_timeout_in_ready", 64'd0, 64'd1);
        r = model(sg, e, s);
        r.due = pcyc + r.lat;
        q.push_back(r);
        bus.in_valid = 1'b1;
        bus.in_sign  = sg;
        bus.in_exp   = e;
        bus.in_sig   = s;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            tick();
            t = t + 1;
        end
        if (q.size() != 0) chk("drain_timeout", 64'(q.size()), 64'd0);
        tick();
    endtask

    res_t m;

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_exp    = '0;
        bus.in_sig    = '0;
        bus.out_ready = 1'b1;

        // Pin the model with hand-computed values.
        m = model(1'b0, 8'h80, 25'h0000100);
        chk("model_lz", {32'(m.lat), 8'(m.e), m.s}, {32'd17, 8'h71, 24'h800000});
        m = model(1'b0, 8'h03, 25'h0000001);
        chk("model_uf", {32'(m.lat), 8'(m.e), m.s, 1'(m.u)}, {32'd4, 8'h00, 24'h000004, 1'b1});
        m = model(1'b0, 8'hFE, 25'h1000001);
        chk("model_ovf", {8'(m.e), m.s, 1'(m.o)}, {8'hFF, 24'h0, 1'b1});
        m = model(1'b0, 8'h80, 25'h1000001);
        chk("model_carry", {32'(m.lat), 8'(m.e), m.s}, {32'd2, 8'h81, 24'h800000});

        tick();
        tick();
        chk("reset_ready_valid", {bus.in_ready, bus.out_valid}, 2'b10);
        chk("reset_outputs", {bus.out_sign, bus.out_exp, bus.out_sig, bus.out_zero,
                              bus.out_underflow, bus.out_overflow}, 36'd0);
        rst = 1'b0;
        tick();

        send(1'b1, 8'h80, 25'h0800000);
        drain();
        send(1'b0, 8'h80, 25'h1000001);
        drain();
        send(1'b0, 8'hFE, 25'h1000001);
        drain();
        send(1'b0, 8'hFF, 25'h1FFFFFF);
        drain();
        send(1'b1, 8'h80, 25'h0000100);
        drain();
        send(1'b1, 8'h40, 25'h0000000);
        drain();
        send(1'b0, 8'h03, 25'h0000001);
        drain();
        send(1'b0, 8'h01, 25'h0012345);
        drain();
        send(1'b0, 8'h02, 25'h0400000);
        drain();
        send(1'b1, 8'h02, 25'h0200000);
        drain();
        send(1'b0, 8'h00, 25'h1800001);
        drain();
        send(1'b0, 8'h9C, 25'h0000003);
        send(1'b1, 8'h10, 25'h0654321);
        drain();

        // Backpressure: result must hold and new input must be refused.
        bus.out_ready = 1'b0;
        send(1'b1, 8'h55, 25'h0ABCDEF);
        for (int i = 0; i < 5 && !bus.out_valid; i++) tick();
        bus.in_valid = 1'b1;
        bus.in_sign  = 1'b0;
        bus.in_exp   = 8'h11;
        bus.in_sig   = 25'h0000000;
        for (int i = 0; i < 3; i++) begin
            chk("stall_ready_valid", {bus.in_ready, bus.out_valid}, 2'b01);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk("handoff_ready_valid", {bus.in_ready, bus.out_valid}, 2'b10);
        for (int i = 0; i < 4; i++) tick();
        chk("no_stray_accept", 64'(q.size()), 64'd0);

        // Reset while shifting discards the in-flight result.
        send(1'b0, 8'h80, 25'h0000100);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        q.delete();
        shown = 0;
        tick();
        rst = 1'b0;
        chk("rst_mid_shift", {bus.in_ready, bus.out_valid, bus.out_exp, bus.out_sig}, {2'b10, 32'd0});
        for (int i = 0; i < 20; i++) tick();
        send(1'b1, 8'h7F, 25'h0C00000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
